// File: rtl/div_pkg.sv
// Shared constants for the M-extension iterative divider.
// Optional feature macro: DIV_FAST_SPECIAL_EN (see div_sequencer).
package div_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    // Undefined funct3 encodings fall back to DIVU, so only REM/REMU pick R.
    function automatic logic f3_rem(input logic [2:0] f3);
        return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between execute and the divider.
// Master is the pipeline side, slave is the divider.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, kill,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// quo_i carries the remaining dividend bits in its MSBs.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller (restoring, one bit per cycle).
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC/FIX.
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic clk,
    input logic rst_n,
    div_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      f3_q, f3_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            sgn_in, a_neg, b_neg, dz_in, ovf_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] step_rem, step_quo;

    assign sgn_in = f3_signed(bus.funct3);
    assign a_neg  = sgn_in & bus.rs1_data[XLEN-1];
    assign b_neg  = sgn_in & bus.rs2_data[XLEN-1];
    assign a_abs  = a_neg ? -bus.rs1_data : bus.rs1_data;
    assign b_abs  = b_neg ? -bus.rs2_data : bus.rs2_data;
    assign dz_in  = (bus.rs2_data == '0);
    assign ovf_in = sgn_in && (bus.rs1_data == MIN_VAL)
                           && (bus.rs2_data == '1);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        f3_d     = f3_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    f3_d    = bus.funct3;
                    quo_d   = a_abs;
                    rem_d   = '0;
                    dvs_d   = b_abs;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = dz_in;
                    ovf_d   = ovf_in;
                    cnt_d   = CNT_W'(XLEN - 1);
                    state_d = CALC;
`ifdef DIV_FAST_SPECIAL_EN
                    if (dz_in || ovf_in) begin
                        quo_d   = dz_in ? '1 : bus.rs1_data;
                        rem_d   = dz_in ? bus.rs1_data : '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                quo_d = qneg_q ? -quo_q : quo_q;
                rem_d = rneg_q ? -rem_q : rem_q;
                // Remainder for x/0 is |x| re-signed, i.e. x itself.
                if (dz_q) begin
                    quo_d = '1;
                end else if (ovf_q) begin
                    quo_d = MIN_VAL;
                    rem_d = '0;
                end
                state_d = DONE;
            end
            DONE: begin
                result_d = f3_rem(f3_q) ? rem_q : quo_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush only hits in-flight work; a fresh start in IDLE survives it.
        if (bus.kill && (state_q != IDLE)) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            f3_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
